// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared constants and helpers for the blitter colour pipe
package blit_pkg;

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_TEXT = 2'd1;
  localparam logic [1:0] MODE_COPY = 2'd2;

  localparam logic [1:0] ROP_SRC = 2'd0;
  localparam logic [1:0] ROP_XOR = 2'd1;
  localparam logic [1:0] ROP_AND = 2'd2;
  localparam logic [1:0] ROP_OR  = 2'd3;

  // Lane counts never exceed 8, so an 8-bit operand covers every mask.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/blit_lane.sv
// rtl/blit_lane.sv - per-lane colour select and transparency compare
import blit_pkg::*;

module blit_lane #(
  parameter int PIXEL_BITS = 8,
  parameter int COLOR_BITS = PIXEL_BITS + 1,
  parameter int LANE_IDX   = 0
) (
  input  logic [1:0]            i_mode,
  input  logic [PIXEL_BITS-1:0] i_src_pixel,
  input  logic [7:0]            i_glyph,
  input  logic [2:0]            i_src_bit,
  input  logic                  i_lane_en,
  input  logic [COLOR_BITS-1:0] i_fg_color,
  input  logic [COLOR_BITS-1:0] i_bg_color,
  input  logic [COLOR_BITS-1:0] i_transparent_color,
  output logic [PIXEL_BITS-1:0] o_pixel,
  output logic                  o_mask
);

  localparam logic [2:0] LANE_OFS = 3'(LANE_IDX % 8);

  logic [2:0]            w_bit_idx;
  logic [COLOR_BITS-1:0] w_color;

  // Glyph bit index wraps within the byte as lanes walk past bit 7.
  assign w_bit_idx = i_src_bit + LANE_OFS;

  always_comb begin
    w_color = i_fg_color;
    case (i_mode)
      MODE_TEXT: w_color = i_glyph[w_bit_idx] ? i_fg_color : i_bg_color;
      MODE_COPY: w_color = {{(COLOR_BITS-PIXEL_BITS){1'b0}}, i_src_pixel};
      default:   w_color = i_fg_color;
    endcase
  end

  // Full-width compare: a transparent colour with the MSB set never matches.
  assign o_mask  = i_lane_en && (w_color != i_transparent_color);
  assign o_pixel = w_color[PIXEL_BITS-1:0];

endmodule

// File: rtl/blit_color_pipe.sv
// rtl/blit_color_pipe.sv - two-stage multi-lane colour select and raster-op pipe
import blit_pkg::*;

module blit_color_pipe #(
  parameter int PIXEL_BITS = 8,
  parameter int LANES      = 4,
  parameter int COLOR_BITS = PIXEL_BITS + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [1:0]                  rop,
  input  logic [LANES*PIXEL_BITS-1:0] src_data,
  input  logic [2:0]                  src_bit,
  input  logic [LANES-1:0]            lane_en,
  input  logic [COLOR_BITS-1:0]       fg_color,
  input  logic [COLOR_BITS-1:0]       bg_color,
  input  logic [COLOR_BITS-1:0]       transparent_color,
  input  logic [LANES*PIXEL_BITS-1:0] dst_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*PIXEL_BITS-1:0] wr_data,
  output logic [LANES-1:0]            wr_mask,
  input  logic                        stat_clear,
  output logic [31:0]                 pixels_written
);

  localparam int W = LANES * PIXEL_BITS;

  logic [W-1:0]     w_lane_pixels;
  logic [LANES-1:0] w_lane_mask;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      blit_lane #(
        .PIXEL_BITS (PIXEL_BITS),
        .COLOR_BITS (COLOR_BITS),
        .LANE_IDX   (g)
      ) u_lane (
        .i_mode              (mode),
        .i_src_pixel         (src_data[g*PIXEL_BITS +: PIXEL_BITS]),
        .i_glyph             (src_data[7:0]),
        .i_src_bit           (src_bit),
        .i_lane_en           (lane_en[g]),
        .i_fg_color          (fg_color),
        .i_bg_color          (bg_color),
        .i_transparent_color (transparent_color),
        .o_pixel             (w_lane_pixels[g*PIXEL_BITS +: PIXEL_BITS]),
        .o_mask              (w_lane_mask[g])
      );
    end
  endgenerate

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_color;
  logic [LANES-1:0] r_s1_mask;
  logic [1:0]       r_s1_rop;
  logic [W-1:0]     r_s1_dst;

  logic             r_s2_valid;
  logic [W-1:0]     r_wr_data;
  logic [LANES-1:0] r_wr_mask;
  logic [31:0]      r_pixels;

  logic w_s2_adv;
  logic w_accept;
  logic w_xfer;

  // Stage 2 drains whenever it is empty or the write port takes the beat.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_s2_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_color <= '0;
      r_s1_mask  <= '0;
      r_s1_rop   <= ROP_SRC;
      r_s1_dst   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_color <= w_lane_pixels;
      r_s1_mask  <= w_lane_mask;
      r_s1_rop   <= rop;
      r_s1_dst   <= dst_data;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  logic [W-1:0] w_rop_data;

  always_comb begin
    w_rop_data = r_s1_color;
    case (r_s1_rop)
      ROP_XOR: w_rop_data = r_s1_color ^ r_s1_dst;
      ROP_AND: w_rop_data = r_s1_color & r_s1_dst;
      ROP_OR:  w_rop_data = r_s1_color | r_s1_dst;
      default: w_rop_data = r_s1_color;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_wr_data <= w_rop_data;
        r_wr_mask <= r_s1_mask;
      end
    end
  end

  logic [7:0] w_mask_ext;
  logic [3:0] w_xfer_pop;

  always_comb begin
    w_mask_ext             = '0;
    w_mask_ext[LANES-1:0]  = r_wr_mask;
  end

  assign w_xfer_pop = w_xfer ? popcount8(w_mask_ext) : 4'd0;

  // A clear coinciding with a transfer still counts that transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pixels <= '0;
    end else if (stat_clear) begin
      r_pixels <= {28'd0, w_xfer_pop};
    end else begin
      r_pixels <= r_pixels + {28'd0, w_xfer_pop};
    end
  end

  assign out_valid      = r_s2_valid;
  assign wr_data        = r_wr_data;
  assign wr_mask        = r_wr_mask;
  assign pixels_written = r_pixels;

endmodule

// File: tb/tb_blit_color_pipe.sv
// tb/tb_blit_color_pipe.sv - self-checking bench for blit_color_pipe
module tb_blit_color_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [1:0]  rop;
  logic [31:0] src_data;
  logic [2:0]  src_bit;
  logic [3:0]  lane_en;
  logic [8:0]  fg_color;
  logic [8:0]  bg_color;
  logic [8:0]  transparent_color;
  logic [31:0] dst_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        stat_clear;
  logic [31:0] pixels_written;

  blit_color_pipe dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mode              (mode),
    .rop               (rop),
    .src_data          (src_data),
    .src_bit           (src_bit),
    .lane_en           (lane_en),
    .fg_color          (fg_color),
    .bg_color          (bg_color),
    .transparent_color (transparent_color),
    .dst_data          (dst_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .wr_data           (wr_data),
    .wr_mask           (wr_mask),
    .stat_clear        (stat_clear),
    .pixels_written    (pixels_written)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    int          acc_cycle;
  } beat_t;

  beat_t       q[$];
  logic [31:0] pix_model;
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat straight from the per-lane colour/mask/rop rules.
  function automatic beat_t ref_beat();
    beat_t b;
    int c, d, r;
    b.data = '0;
    b.mask = '0;
    b.acc_cycle = 0;
    for (int i = 0; i < 4; i++) begin
      case (mode)
        2'd1:    c = src_data[(int'(src_bit) + i) % 8] ? int'(fg_color) : int'(bg_color);
        2'd2:    c = int'((src_data >> (8 * i)) & 32'hFF);
        default: c = int'(fg_color);
      endcase
      d = int'((dst_data >> (8 * i)) & 32'hFF);
      case (rop)
        2'd0:    r = c;
        2'd1:    r = c ^ d;
        2'd2:    r = c & d;
        default: r = c | d;
      endcase
      b.data[8*i +: 8] = 8'(r & 255);
      b.mask[i] = lane_en[i] && (c != int'(transparent_color));
    end
    return b;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  // A beat accepted in cycle n is visible from cycle n+2 once it heads the queue;
  // at most two beats are ever in flight.
  task automatic tick(output bit acc);
    bit    exp_ir, exp_ov, xfer;
    int    pop;
    beat_t b;
    acc = 1'b0;
    #1;
    if (reset) begin
      q.delete();
      pix_model = '0;
    end else begin
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (q[0].acc_cycle <= cyc - 2);
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("pixels_written", 64'(pixels_written), 64'(pix_model));
      if (exp_ov) begin
        chk("wr_data", 64'(wr_data), 64'(q[0].data));
        chk("wr_mask", 64'(wr_mask), 64'(q[0].mask));
      end
      xfer = exp_ov && out_ready;
      pop  = xfer ? $countones(q[0].mask) : 0;
      if (xfer) void'(q.pop_front());
      if (stat_clear) pix_model = 32'(pop);
      else            pix_model = pix_model + 32'(pop);
      acc = in_valid && exp_ir;
      if (acc) begin
        b = ref_beat();
        b.acc_cycle = cyc;
        q.push_back(b);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send_one();
    bit a;
    in_valid = 1'b1;
    tick(a);
    chk("send_accept", 64'(a), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int bc;
    int blocked;
    checks = 0; errors = 0; cyc = 0; pix_model = '0;
    reset = 1'b1; in_valid = 1'b0; mode = 2'd0; rop = 2'd0;
    src_data = '0; src_bit = '0; lane_en = 4'hF; fg_color = '0; bg_color = '0;
    transparent_color = 9'h100; dst_data = '0; out_ready = 1'b1; stat_clear = 1'b0;
    @(posedge clock); #1;
    tick(acc);
    tick(acc);
    reset = 1'b0;
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_mask", 64'(wr_mask), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick(acc);

    // FILL
    mode = 2'd0; rop = 2'd0; fg_color = 9'h02A; transparent_color = 9'h100; lane_en = 4'hF;
    send_one();
    tick(acc);
    chk("fill_data", 64'(wr_data), 64'h2A2A2A2A);
    chk("fill_mask", 64'(wr_mask), 64'hF);
    tick(acc);
    chk("fill_count", 64'(pixels_written), 64'd4);

    // TEXT
    mode = 2'd1; src_data = 32'h000000A5; src_bit = 3'd0;
    fg_color = 9'h00F; bg_color = 9'h000; transparent_color = 9'h000;
    send_one();
    tick(acc);
    chk("text_data", 64'(wr_data), 64'h000F000F);
    chk("text_mask", 64'(wr_mask), 64'h5);
    tick(acc);

    // TEXT wrap across the glyph byte
    src_data = 32'h00000080; src_bit = 3'd6;
    fg_color = 9'h011; bg_color = 9'h022; transparent_color = 9'h100;
    send_one();
    tick(acc);
    chk("wrap_data", 64'(wr_data), 64'h22221122);
    chk("wrap_mask", 64'(wr_mask), 64'hF);
    tick(acc);

    // COPY + XOR, lane 1 (0x03) is transparent
    mode = 2'd2; rop = 2'd1; src_data = 32'h01020304; dst_data = 32'hFF00FF00;
    transparent_color = 9'h003;
    send_one();
    tick(acc);
    chk("copy_xor_data", 64'(wr_data), 64'hFE02FC04);
    chk("copy_xor_mask", 64'(wr_mask), 64'hD);
    tick(acc);

    // Backpressure: 4 beats, out_ready low for 3 cycles mid-stream
    mode = 2'd2; rop = 2'd0; transparent_color = 9'h100; lane_en = 4'hF;
    bc = 0; blocked = 0;
    for (int k = 0; k < 4; k++) begin
      src_data = 32'h11111111 * (k + 1);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        out_ready = !(bc >= 2 && bc <= 4);
        tick(acc);
        bc++;
        if (!acc) blocked++;
      end
      chk("bp_accept", 64'(acc), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 4; t++) tick(acc);
    chk("bp_blocked", 64'(blocked), 64'd3);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset with both stages full and the output stalled
    mode = 2'd0; fg_color = 9'h055; out_ready = 1'b0;
    send_one();
    send_one();
    tick(acc);
    reset = 1'b1;
    tick(acc);
    reset = 1'b0; out_ready = 1'b1;
    chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_count", 64'(pixels_written), 64'd0);
    tick(acc);
    send_one();
    tick(acc);
    tick(acc);
    chk("pre_clear_count", 64'(pixels_written), 64'd4);
    lane_en = 4'b0111;
    send_one();
    tick(acc);
    stat_clear = 1'b1;
    tick(acc);
    stat_clear = 1'b0;
    chk("clear_count", 64'(pixels_written), 64'd3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid   = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      stat_clear = ($urandom_range(0, 15) == 0);
      mode       = 2'($urandom);
      rop        = 2'($urandom);
      src_data   = $urandom & 32'h0F0F0F0F;
      src_bit    = 3'($urandom);
      lane_en    = 4'($urandom);
      fg_color   = {1'b0, 8'($urandom_range(0, 7))};
      bg_color   = {1'b0, 8'($urandom)};
      dst_data   = $urandom;
      case ($urandom_range(0, 3))
        0:       transparent_color = 9'h100;
        1:       transparent_color = fg_color;
        2:       transparent_color = {1'b0, 8'($urandom_range(0, 3))};
        default: transparent_color = 9'($urandom);
      endcase
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
    for (int t = 0; t < 4; t++) tick(acc);
    chk("final_drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
